// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, requester ids,
// FSM states and the captured-request record.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RMW_WR = 2'b10,
        RESP   = 2'b11
    } state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] wdata;
    } req_t;

    // The reserved size code behaves as a full word.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_WORD : sz;
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Requester load/store port: req held until gnt, one transaction in flight,
// completion signalled by a one-cycle rvalid carrying rdata/err.
interface dmem_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, size, uns, addr, wdata,
                    input  gnt, rvalid, rdata, err);
    modport slave  (input  req, we, size, uns, addr, wdata,
                    output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_lane.sv
// Combinational byte-lane logic: load extraction with sign/zero extension and
// sub-word store merge. Half accesses ignore off[0], word accesses ignore off.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] ld_word_i,
    input  logic [31:0] st_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_data_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte   = ld_word_i[{off_i, 3'b000} +: 8];
        ld_half   = off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        ld_data_o = ld_word_i;
        st_data_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                ld_data_o = uns_i ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
                st_data_o = st_word_i;
                st_data_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                ld_data_o = uns_i ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
                st_data_o = off_i[1] ? {wdata_i[15:0], st_word_i[15:0]}
                                     : {st_word_i[31:16], wdata_i[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/dmem_ctrl.sv
// Two-requester (cpu/dbg) round-robin controller for a single-port word RAM; load and word
// store complete 2 cycles after gnt, sub-word stores 3 (read-modify-write). DMEM_MISALIGN_TRAP_EN traps misalignment.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  cpu,
    dmem_ctrl_if.slave  dbg,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_din_o,
    input  logic [31:0] ram_dout_i,
    output logic        busy_o
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    state_t             state_q, state_d;
    logic               sel_q, last_q;
    req_t               req_q, cap_req;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        merge_q, rdata_cpu_q, rdata_dbg_q;
    logic [31:0]        cap_addr, ld_data, st_data;
    logic               win_dbg, gnt_en, ld_en, merge_en, trap;
    logic               unused_addr;

    // dbg wins only when cpu is idle or cpu took the previous grant.
    assign win_dbg = dbg.req & (~cpu.req | (last_q == PORT_CPU));

    always_comb begin
        cap_addr      = win_dbg ? dbg.addr : cpu.addr;
        cap_req.we    = win_dbg ? dbg.we : cpu.we;
        cap_req.size  = norm_size(win_dbg ? dbg.size : cpu.size);
        cap_req.uns   = win_dbg ? dbg.uns : cpu.uns;
        cap_req.off   = cap_addr[1:0];
        cap_req.wdata = win_dbg ? dbg.wdata : cpu.wdata;
    end
    assign unused_addr = ^cap_addr[31:IDX_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = misaligned(req_q.size, req_q.off);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_en    = 1'b0;
        ld_en     = 1'b0;
        merge_en  = 1'b0;
        ram_we_o  = 1'b0;
        ram_din_o = req_q.wdata;
        case (state_q)
            IDLE: begin
                if (cpu.req || dbg.req) begin
                    gnt_en  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!trap) begin
                    if (!req_q.we) begin
                        ld_en = 1'b1;
                    end else if (req_q.size == SZ_WORD) begin
                        ram_we_o = 1'b1;
                    end else begin
                        merge_en = 1'b1;
                        state_d  = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                ram_we_o  = 1'b1;
                ram_din_o = st_data;
                state_d   = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= PORT_CPU;
            last_q      <= PORT_DBG;
            req_q       <= '0;
            idx_q       <= '0;
            merge_q     <= '0;
            rdata_cpu_q <= '0;
            rdata_dbg_q <= '0;
        end else begin
            state_q <= state_d;
            if (gnt_en) begin
                sel_q  <= win_dbg;
                last_q <= win_dbg;
                req_q  <= cap_req;
                idx_q  <= cap_addr[IDX_W+1:2];
            end
            if (merge_en) merge_q <= ram_dout_i;
            if (ld_en && (sel_q == PORT_CPU)) rdata_cpu_q <= ld_data;
            if (ld_en && (sel_q == PORT_DBG)) rdata_dbg_q <= ld_data;
        end
    end

    dmem_lane u_lane (
        .size_i    (req_q.size),
        .uns_i     (req_q.uns),
        .off_i     (req_q.off),
        .ld_word_i (ram_dout_i),
        .st_word_i (merge_q),
        .wdata_i   (req_q.wdata),
        .ld_data_o (ld_data),
        .st_data_o (st_data)
    );

    assign ram_addr_o = 32'(idx_q) << 2;
    assign busy_o     = (state_q != IDLE);

    assign cpu.gnt    = gnt_en & ~win_dbg;
    assign dbg.gnt    = gnt_en & win_dbg;
    assign cpu.rvalid = (state_q == RESP) && (sel_q == PORT_CPU);
    assign dbg.rvalid = (state_q == RESP) && (sel_q == PORT_DBG);
    assign cpu.rdata  = rdata_cpu_q;
    assign dbg.rdata  = rdata_dbg_q;
    assign cpu.err    = cpu.rvalid & trap;
    assign dbg.err    = dbg.rvalid & trap;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, arbitration and reset-abort sequences,
// then random accesses against a byte-arithmetic memory model.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int MEM_WORDS = 256;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_we, busy;
    logic [31:0] ram_addr, ram_din, ram_dout;
    logic [31:0] mem     [0:MEM_WORDS-1];
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          gq[$];

    always #5 clk = ~clk;

    dmem_ctrl_if cpu_if ();
    dmem_ctrl_if dbg_if ();

    dmem_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu        (cpu_if),
        .dbg        (dbg_if),
        .ram_we_o   (ram_we),
        .ram_addr_o (ram_addr),
        .ram_din_o  (ram_din),
        .ram_dout_i (ram_dout),
        .busy_o     (busy)
    );

    assign ram_dout = mem[ram_addr[9:2]];
    always @(posedge clk) if (ram_we) mem[ram_addr[9:2]] <= ram_din;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("ram_addr_low", {30'b0, ram_addr[1:0]}, 32'h0);
            chk("gnt_both", {31'b0, cpu_if.gnt & dbg_if.gnt}, 32'h0);
            chk("gnt_busy", {31'b0, (cpu_if.gnt | dbg_if.gnt) & busy}, 32'h0);
            chk("we_idle", {31'b0, ram_we & ~busy}, 32'h0);
            if (cpu_if.gnt) gq.push_back(1'b0);
            if (dbg_if.gnt) gq.push_back(1'b1);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive(input bit p, input bit req, input bit we, input logic [1:0] sz,
                         input bit uns, input logic [31:0] a, input logic [31:0] wd);
        if (p) begin
            dbg_if.req = req; dbg_if.we = we; dbg_if.size = sz;
            dbg_if.uns = uns; dbg_if.addr = a; dbg_if.wdata = wd;
        end else begin
            cpu_if.req = req; cpu_if.we = we; cpu_if.size = sz;
            cpu_if.uns = uns; cpu_if.addr = a; cpu_if.wdata = wd;
        end
    endtask

    function automatic bit gnt_of(input bit p);    return p ? dbg_if.gnt : cpu_if.gnt;       endfunction
    function automatic bit rv_of(input bit p);     return p ? dbg_if.rvalid : cpu_if.rvalid; endfunction
    function automatic logic [31:0] rd_of(input bit p); return p ? dbg_if.rdata : cpu_if.rdata; endfunction
    function automatic bit er_of(input bit p);     return p ? dbg_if.err : cpu_if.err;       endfunction

    // lat/welat are cycles after the grant cycle; -1 / 0 when never seen.
    task automatic access(input bit p, input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit er, output int lat, output int welat);
        int t = 0;
        int c = 0;
        rd = 32'hx; er = 1'b0; lat = -1; welat = 0;
        @(posedge clk); #1;
        drive(p, 1'b1, we, sz, uns, a, wd);
        @(negedge clk);
        while (!gnt_of(p) && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        drive(p, 1'b0, we, sz, uns, a, wd);
        if (t >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL gnt_timeout: port %0d never granted", p);
            return;
        end
        while (lat < 0 && c < 10) begin
            @(negedge clk);
            c++;
            if (ram_we && welat == 0) welat = c;
            if (rv_of(p)) begin
                lat = c; rd = rd_of(p); er = er_of(p);
            end
        end
    endtask

    task automatic check_reset_state();
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_we", {31'b0, ram_we}, 32'h0);
        chk("rst_cpu_gnt", {31'b0, cpu_if.gnt}, 32'h0);
        chk("rst_dbg_gnt", {31'b0, dbg_if.gnt}, 32'h0);
        chk("rst_cpu_rv", {31'b0, cpu_if.rvalid}, 32'h0);
        chk("rst_dbg_rv", {31'b0, dbg_if.rvalid}, 32'h0);
        chk("rst_cpu_err", {31'b0, cpu_if.err}, 32'h0);
        chk("rst_dbg_err", {31'b0, dbg_if.err}, 32'h0);
        chk("rst_cpu_rdata", cpu_if.rdata, 32'h0);
        chk("rst_dbg_rdata", dbg_if.rdata, 32'h0);
    endtask

    // Reference model: plain byte arithmetic over a word array.
    function automatic longint nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction
    function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
        return TRAP && (({32'b0, a} % nbytes(sz)) != 0);
    endfunction
    function automatic int ref_idx(input logic [31:0] a);
        return int'(({32'b0, a} / 4) % MEM_WORDS);
    endfunction
    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
        longint n, aa, sh, v;
        n  = nbytes(sz);
        aa = {32'b0, a};
        sh = ((aa - (aa % n)) % 4) * 8;
        v  = ({32'b0, ref_mem[ref_idx(a)]} >> sh) & ((64'd1 << (8 * n)) - 1);
        if (!uns && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        return 32'(v);
    endfunction
    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        longint n, aa, sh, m, w;
        n  = nbytes(sz);
        aa = {32'b0, a};
        sh = ((aa - (aa % n)) % 4) * 8;
        m  = (64'd1 << (8 * n)) - 1;
        w  = {32'b0, ref_mem[ref_idx(a)]};
        w  = (w & ~(m << sh)) | (({32'b0, wd} & m) << sh);
        ref_mem[ref_idx(a)] = 32'(w);
    endtask

    typedef struct {
        bit p; bit we; logic [1:0] sz; bit uns;
        logic [31:0] a; logic [31:0] wd;
        logic [31:0] erd; bit eer; int elat; int ewe;
    } vec_t;
    localparam int NV = 23;
    vec_t tv [NV];

    logic [31:0] rd, rd2, rd3, rd4, erd;
    bit          er, er2, er3, er4, p, we, uns, mis;
    int          lat, lat2, lat3, lat4, wl, wl2, wl3, wl4, rvc, elat, ewe;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    logic [31:0] last_rd [2];

    initial begin
        tv[0]  = '{1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1};
        tv[1]  = '{1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0};
        tv[2]  = '{1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, 32'hDEADBEEF, 1'b0, 2, 1};
        tv[3]  = '{1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h123456AA, 32'hDEADBEEF, 1'b0, 3, 2};
        tv[4]  = '{1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h1122AA44, 1'b0, 2, 0};
        tv[5]  = '{1'b0, 1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, 32'h1122AA44, TRAP, 2, 0};
        tv[6]  = '{1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0};
        tv[7]  = '{1'b0, 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2, 0};
        tv[8]  = '{1'b1, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'h00001122, 1'b0, 2, 0};
        tv[9]  = '{1'b1, 1'b1, SZ_HALF, 1'b0, 32'h12, 32'hFFFF8001, 32'h00001122, 1'b0, 3, 2};
        tv[10] = '{1'b1, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 2, 0};
        tv[11] = '{1'b1, 1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 32'h00008001, 1'b0, 2, 0};
        tv[12] = '{1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h8001AA44, 1'b0, 2, 0};
        tv[13] = '{1'b0, 1'b1, 2'b11,   1'b0, 32'h20, 32'hCAFEF00D, 32'h000000AA, 1'b0, 2, 1};
        tv[14] = '{1'b0, 1'b0, 2'b11,   1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0};
        tv[15] = '{1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0, 32'h01234567, 32'h8001AA44, 1'b0, 2, 1};
        tv[16] = '{1'b1, 1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0, 32'h01234567, 1'b0, 2, 0};
        tv[17] = '{1'b0, 1'b1, SZ_WORD, 1'b0, 32'hFFFFFC04, 32'h0BADF00D, 32'hCAFEF00D, 1'b0, 2, 1};
        tv[18] = '{1'b0, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 32'h0BADF00D, 1'b0, 2, 0};
        tv[19] = '{1'b1, 1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0,
                   TRAP ? 32'h01234567 : 32'hFFFF8001, TRAP, 2, 0};
        tv[20] = '{1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h7, 32'h0000005A, 32'h0BADF00D, 1'b0, 3, 2};
        tv[21] = '{1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h7, 32'h0, 32'h0000005A, 1'b0, 2, 0};
        tv[22] = '{1'b0, 1'b0, SZ_HALF, 1'b0, 32'h6, 32'h0, 32'h00005AAD, 1'b0, 2, 0};

        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        drive(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check_reset_state();
        @(posedge clk); #1 rst = 1'b0;

        // Simultaneous requests twice: cpu has priority first, then alternation.
        gq.delete();
        fork
            begin
                access(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, rd, er, lat, wl);
                access(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h44, 32'h0, rd2, er2, lat2, wl2);
            end
            begin
                access(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h48, 32'h0, rd3, er3, lat3, wl3);
                access(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h4C, 32'h0, rd4, er4, lat4, wl4);
            end
        join
        chk("rr_count", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            chk($sformatf("rr_order%0d", i), {31'b0, gq[i]}, i % 2);
        chk("rr_lat_cpu0", lat, 2);
        chk("rr_lat_cpu1", lat2, 2);
        chk("rr_lat_dbg0", lat3, 2);
        chk("rr_lat_dbg1", lat4, 2);

        for (int i = 0; i < NV; i++) begin
            access(tv[i].p, tv[i].we, tv[i].sz, tv[i].uns, tv[i].a, tv[i].wd, rd, er, lat, wl);
            chk($sformatf("v%0d_rdata", i), rd, tv[i].erd);
            chk($sformatf("v%0d_err", i), {31'b0, er}, {31'b0, tv[i].eer});
            chk($sformatf("v%0d_lat", i), lat, tv[i].elat);
            chk($sformatf("v%0d_we_cycle", i), wl, tv[i].ewe);
        end

        // Reset during RMW_WR of a half store must not touch RAM or respond.
        access(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'h55667788, rd, er, lat, wl);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, SZ_HALF, 1'b0, 32'h32, 32'h0000BEEF);
        @(negedge clk);
        chk("abort_gnt", {31'b0, cpu_if.gnt}, 32'h1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("abort_pre_we", {31'b0, ram_we}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state();
        @(posedge clk); #1 rst = 1'b0;
        rvc = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_if.rvalid || dbg_if.rvalid) rvc++;
        end
        chk("abort_rvalid", rvc, 0);
        chk("abort_mem", mem[12], 32'h55667788);
        access(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, rd, er, lat, wl);
        chk("abort_load", rd, 32'h55667788);

        last_rd[0] = 32'h55667788;
        last_rd[1] = 32'h0;
        for (int i = 0; i < 300; i++) begin
            p   = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            a   = 32'h100 | ($urandom & 32'hFFFF_FC3F);
            wd  = $urandom;
            mis = ref_mis(sz, a);
            elat = (!mis && we && nbytes(sz) < 4) ? 3 : 2;
            ewe  = (mis || !we) ? 0 : (nbytes(sz) < 4) ? 2 : 1;
            if (!mis && !we) last_rd[p] = ref_load(sz, uns, a);
            if (!mis && we) ref_store(sz, a, wd);
            erd = last_rd[p];
            access(p, we, sz, uns, a, wd, rd, er, lat, wl);
            chk("rnd_rdata", rd, erd);
            chk("rnd_err", {31'b0, er}, {31'b0, mis});
            chk("rnd_lat", lat, elat);
            chk("rnd_we_cycle", wl, ewe);
        end
        for (int i = 64; i < 80; i++)
            chk($sformatf("rnd_mem%0d", i), mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
